sync_monitor: RTL and testbench

Receive-side counterpart of the board sync generator. Samples an asynchronous square-wave sync input and detects its edges. Measures each half-period in `clk` cycles and declares lock once the input matches the expected toggle interval. Sits at the input of a board that slaves to another board's `syncout`, and feeds edge strobes and lock status to local timestamping logic.

---
 rtl/sync_pkg.sv | 14 +
 rtl/sync_edge_detect.sv | 41 ++++
 rtl/sync_monitor.sv | 166 ++++++++++++++++
 tb/tb_sync_monitor.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/sync_pkg.sv
// Shared definitions for the sync_monitor block and its edge detector.
//   sync_state_t : monitor state (IDLE, ACQUIRE, LOCKED)
//   SYNC_STAGES  : depth of the metastability synchronizer on async inputs
package sync_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } sync_state_t;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronizes one asynchronous level input and reports its edges.
// An edge is registered one cycle after the synchronized level differs from
// the previous-value flop, so an input change first sampled at clock edge E0
// appears on edge_det after clock edge E0+2.
// Ports:
//   clk       : sampling clock
//   rst       : synchronous active-high reset (clears every flop)
//   async_in  : asynchronous level input
//   edge_det  : one-cycle strobe per detected edge
//   edge_rise : new level of the input, meaningful while edge_det is high
module sync_edge_detect import sync_pkg::*; #(
  parameter int STAGES = SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic edge_det,
  output logic edge_rise
);

  logic [STAGES-1:0] sync_sr;
  logic              prev_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_sr   <= '0;
      prev_p0   <= 1'b0;
      edge_det  <= 1'b0;
      edge_rise <= 1'b0;
    end else begin
      // synchronizer stages
      sync_sr   <= {sync_sr[STAGES-2:0], async_in};
      // previous-value stage
      prev_p0   <= sync_sr[STAGES-1];
      // registered edge / polarity stage
      edge_det  <= sync_sr[STAGES-1] ^ prev_p0;
      edge_rise <= sync_sr[STAGES-1];
    end
  end

endmodule

// File: rtl/sync_monitor.sv
// Receive-side sync monitor. Detects edges of an asynchronous square wave,
// measures each half-period in clk cycles and declares lock once LOCK_COUNT
// consecutive edges land within TOLERANCE of FREQ_CLK. A stalled input
// (no edge for 2*FREQ_CLK cycles) produces a timeout strobe and returns the
// block to IDLE.
// Ports:
//   clk          : only clock
//   reset        : synchronous active-high reset
//   syncin       : asynchronous sync square wave
//   edge_valid   : one-cycle strobe per detected edge
//   edge_rising  : polarity of the edge, valid with edge_valid
//   half_period  : last measured edge-to-edge interval (clk cycles)
//   period_valid : half_period holds a real measurement
//   edge_count   : edges seen since reset, wraps modulo 2^32
//   locked       : input within tolerance for LOCK_COUNT consecutive edges
//   timeout      : one-cycle strobe when the input stalls
module sync_monitor import sync_pkg::*; #(
  parameter int unsigned FREQ_CLK   = 2000000,
  parameter int unsigned TOLERANCE  = 16,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int          CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             syncin,
  output logic             edge_valid,
  output logic             edge_rising,
  output logic [CNT_W-1:0] half_period,
  output logic             period_valid,
  output logic [31:0]      edge_count,
  output logic             locked,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(2 * FREQ_CLK);
  localparam logic [CNT_W-1:0] NOMINAL_CNT = CNT_W'(FREQ_CLK);
  localparam logic [CNT_W-1:0] TOL_CNT     = CNT_W'(TOLERANCE);
  localparam int               GOOD_W      = $clog2(LOCK_COUNT + 1);
  localparam logic [GOOD_W-1:0] GOOD_LAST  = GOOD_W'(LOCK_COUNT - 1);
  localparam logic [GOOD_W-1:0] GOOD_FULL  = GOOD_W'(LOCK_COUNT);

  // |meas - FREQ_CLK| <= TOLERANCE, evaluated one bit wider and signed so
  // the subtraction can never wrap.
  function automatic logic within_tol(input logic [CNT_W-1:0] meas);
    logic signed [CNT_W:0] diff;
    diff = $signed({1'b0, meas}) - $signed({1'b0, NOMINAL_CNT});
    if (diff < 0) diff = -diff;
    return diff <= $signed({1'b0, TOL_CNT});
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  logic              edge_det;
  logic              edge_rise;
  sync_state_t       state;
  sync_state_t       state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [GOOD_W-1:0] good_cnt;
  logic [GOOD_W-1:0] good_nxt;
  logic              meas_upd;
  logic              stall;
  logic              good_edge;

  sync_edge_detect #(
    .STAGES (SYNC_STAGES)
  ) u_edge (
    .clk       (clk),
    .rst       (reset),
    .async_in  (syncin),
    .edge_det  (edge_det),
    .edge_rise (edge_rise)
  );

  assign good_edge = within_tol(cnt);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      good_cnt <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      good_cnt <= good_nxt;
    end
  end

  // cnt loads 1 the cycle after an edge, so edges N cycles apart read N.
  // An edge takes priority over the stall check on the same cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    good_nxt  = good_cnt;
    meas_upd  = 1'b0;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (edge_det) begin
          state_nxt = ACQUIRE;
          good_nxt  = '0;
          cnt_nxt   = CNT_W'(1);
        end
      end
      ACQUIRE, LOCKED: begin
        cnt_nxt = sat_inc(cnt);
        if (edge_det) begin
          cnt_nxt  = CNT_W'(1);
          meas_upd = 1'b1;
          if (!good_edge) begin
            state_nxt = ACQUIRE;
            good_nxt  = '0;
          end else if (state == ACQUIRE) begin
            if (good_cnt == GOOD_LAST) begin
              state_nxt = LOCKED;
              good_nxt  = GOOD_FULL;
            end else begin
              good_nxt = good_cnt + GOOD_W'(1);
            end
          end
        end else if (cnt == TIMEOUT_CNT) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          good_nxt  = '0;
          stall     = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        good_nxt  = '0;
      end
    endcase
  end

  // output register stage
  always_ff @(posedge clk) begin
    if (reset) begin
      edge_valid   <= 1'b0;
      edge_rising  <= 1'b0;
      half_period  <= '0;
      period_valid <= 1'b0;
      edge_count   <= '0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      edge_valid <= edge_det;
      timeout    <= stall;
      locked     <= (state_nxt == LOCKED);
      if (edge_det) begin
        edge_rising <= edge_rise;
        edge_count  <= edge_count + 32'd1;
      end
      if (meas_upd) begin
        half_period  <= cnt;
        period_valid <= 1'b1;
      end else if (stall) begin
        period_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sync_monitor.sv
// Self-checking bench for sync_monitor with FREQ_CLK=8, TOLERANCE=1,
// LOCK_COUNT=3. A timestamp-based reference model predicts every output on
// every cycle from the sequence of syncin samples.
module tb_sync_monitor;

  localparam int F     = 8;
  localparam int T     = 1;
  localparam int L     = 3;
  localparam int CNT_W = 32;

  logic             clk;
  logic             reset;
  logic             syncin;
  logic             edge_valid;
  logic             edge_rising;
  logic [CNT_W-1:0] half_period;
  logic             period_valid;
  logic [31:0]      edge_count;
  logic             locked;
  logic             timeout;

  sync_monitor #(
    .FREQ_CLK   (F),
    .TOLERANCE  (T),
    .LOCK_COUNT (L),
    .CNT_W      (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .syncin       (syncin),
    .edge_valid   (edge_valid),
    .edge_rising  (edge_rising),
    .half_period  (half_period),
    .period_valid (period_valid),
    .edge_count   (edge_count),
    .locked       (locked),
    .timeout      (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit          hist[$];
  int          k = 0;
  int          last_k = 0;
  int          m_state = 0;   // 0 idle, 1 acquiring, 2 locked
  int          good = 0;
  logic        exp_ev, exp_rise, exp_pv, exp_lock, exp_to;
  logic [31:0] exp_half, exp_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic model(input logic rst_s, input logic smp);
    int iv;
    if (rst_s) begin
      hist = '{1'b0, 1'b0, 1'b0, 1'b0};
      m_state = 0; good = 0;
      exp_ev = 0; exp_rise = 0; exp_pv = 0; exp_lock = 0; exp_to = 0;
      exp_half = 0; exp_cnt = 0;
    end else begin
      hist.push_back(smp);
      while (hist.size() > 5) void'(hist.pop_front());
      // hist[0..4] are samples from cycles k-4..k; output lags by 3 cycles
      exp_ev = (hist[1] != hist[0]);
      exp_to = 0;
      if (exp_ev) begin
        exp_rise = hist[1];
        exp_cnt  = exp_cnt + 1;
        if (m_state == 0) begin
          m_state = 1; good = 0;
        end else begin
          iv = k - last_k;
          exp_half = iv;
          exp_pv = 1;
          if (iv < F - T || iv > F + T) begin
            m_state = 1; good = 0;
          end else if (m_state == 1) begin
            good++;
            if (good == L) m_state = 2;
          end
        end
        last_k = k;
      end else if (m_state != 0 && (k - last_k) == 2 * F) begin
        exp_to = 1; m_state = 0; exp_pv = 0; good = 0;
      end
      exp_lock = (m_state == 2);
    end
  endtask

  task automatic step();
    logic rst_s, smp;
    @(posedge clk);
    rst_s = reset;
    smp   = syncin;
    #1;
    k++;
    model(rst_s, smp);
    chk("edge_valid", {31'b0, edge_valid}, {31'b0, exp_ev});
    if (exp_ev) chk("edge_rising", {31'b0, edge_rising}, {31'b0, exp_rise});
    chk("half_period", half_period, exp_half);
    chk("period_valid", {31'b0, period_valid}, {31'b0, exp_pv});
    chk("edge_count", edge_count, exp_cnt);
    chk("locked", {31'b0, locked}, {31'b0, exp_lock});
    chk("timeout", {31'b0, timeout}, {31'b0, exp_to});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic toggle_run(input int n);
    syncin = ~syncin;
    run(n);
  endtask

  initial begin
    int iv;
    reset  = 1'b1;
    syncin = 1'b0;
    hist   = '{1'b0, 1'b0, 1'b0, 1'b0};
    run(2);
    reset = 1'b0;
    run(4);

    // nominal lock: toggle every 8 cycles
    for (int i = 0; i < 6; i++) toggle_run(8);
    chk("nominal_locked", {31'b0, locked}, 32'd1);
    chk("nominal_half", half_period, 32'd8);

    // tolerance bounds
    toggle_run(10);
    toggle_run(7);
    toggle_run(9);
    toggle_run(9);
    toggle_run(10);
    for (int i = 0; i < 4; i++) toggle_run(8);

    // stall while locked, then restart
    run(30);
    chk("stall_pv", {31'b0, period_valid}, 32'd0);
    chk("stall_half", half_period, 32'd8);
    toggle_run(8);
    toggle_run(8);

    // edge coincident with timeout
    toggle_run(16);
    toggle_run(8);
    for (int i = 0; i < 4; i++) toggle_run(8);

    // reset mid-lock with syncin high
    if (syncin == 1'b0) toggle_run(8);
    reset = 1'b1;
    run(1);
    reset = 1'b0;
    run(25);

    // fast glitches
    for (int i = 0; i < 6; i++) toggle_run(1);
    run(8);
    chk("glitch_unlocked", {31'b0, locked}, 32'd0);
    run(20);

    // randomized intervals with occasional reset
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b1;
        run(1);
        reset = 1'b0;
      end
      iv = $urandom_range(0, 3) == 0 ? int'($urandom_range(1, 20)) : int'($urandom_range(F - T - 1, F + T + 1));
      toggle_run(iv);
    end
    run(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
